dehaze_recover: RTL

Parametrised scene-radiance recovery stage for the dehaze pipeline: computes J = A + (I − A)·(2^TW−1)/max(t, T_MIN) + OFFSET per channel, using a per-frame atmospheric light vector and a per-pixel transmission value. It sits after the transmission/atmospheric-light estimators and drives the video output path. It is a 3-stage pipeline with matched sync delay, a reciprocal ROM instead of a divider, saturation, and per-frame clip statistics.

---
 rtl/dehaze_pkg.sv | 29 ++
 rtl/dehaze_recover_if.sv | 34 +++
 rtl/dehaze_recover_ch.sv | 68 ++++++
 rtl/dehaze_recover.sv | 103 ++++++++++
 4 files changed

// File: rtl/dehaze_pkg.sv
// dehaze_pkg: constants and helpers shared by the dehaze pipeline stages.
//   DEHAZE_DW / DEHAZE_TW / DEHAZE_RF : default channel, transmission and
//                                       reciprocal-fraction widths
//   recip_fn  : reciprocal ROM fill, round(((2^tw-1) << rf) / t)
//   clamp_fn  : clamp a signed value into [0, 2^dw-1]
package dehaze_pkg;

  localparam int DEHAZE_DW = 8;
  localparam int DEHAZE_TW = 8;
  localparam int DEHAZE_RF = 10;

  function automatic int unsigned recip_fn(int unsigned t, int unsigned tw, int unsigned rf);
    longint unsigned num;
    longint unsigned den;
    num = ((longint'(1) << tw) - 1) << rf;
    den = longint'(t);
    if (t == 0) return 0;
    return int'((num + den / 2) / den);
  endfunction

  function automatic longint clamp_fn(longint v, int unsigned dw);
    longint hi;
    hi = (longint'(1) << dw) - 1;
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/dehaze_recover_if.sv
// dehaze_recover_if: video bus into and out of the radiance recovery stage.
//   i_data/i_t/i_atm/i_hsync/i_vsync/i_de : hazy pixel, transmission,
//                                           atmospheric light, input syncs
//   o_data/o_hsync/o_vsync/o_de           : recovered pixel and delayed syncs
//   o_clip_cnt                            : clipped-pixel count of last frame
// slave modport is the recovery stage; master is the upstream/downstream side.
interface dehaze_recover_if #(
  parameter int DW = 8,
  parameter int CH = 3,
  parameter int TW = 8,
  parameter int CW = 22
) ();
  logic [CH*DW-1:0] i_data;
  logic [TW-1:0]    i_t;
  logic [CH*DW-1:0] i_atm;
  logic             i_hsync;
  logic             i_vsync;
  logic             i_de;
  logic [CH*DW-1:0] o_data;
  logic             o_hsync;
  logic             o_vsync;
  logic             o_de;
  logic [CW-1:0]    o_clip_cnt;

  modport slave (
    input  i_data, i_t, i_atm, i_hsync, i_vsync, i_de,
    output o_data, o_hsync, o_vsync, o_de, o_clip_cnt
  );

  modport master (
    output i_data, i_t, i_atm, i_hsync, i_vsync, i_de,
    input  o_data, o_hsync, o_vsync, o_de, o_clip_cnt
  );
endinterface

// File: rtl/dehaze_recover_ch.sv
// dehaze_recover_ch: one colour channel of the recovery datapath.
//   S1 registers diff = I - A and A; S2 registers diff * recip;
//   S3 rounds, adds A + OFFSET, clamps and registers o_pix (0 when !i_de_s2).
//   pixelclk, reset_n : clock, async active-low reset
//   i_pix, i_atm      : channel pixel and frame atmospheric light
//   i_recip           : S1-registered reciprocal, aligned with diff
//   i_de_s2           : data enable at the S2/S3 boundary
//   o_pix             : recovered channel value (registered)
//   o_clip            : S3 clamp flag (combinational, consumed by the counter)
import dehaze_pkg::*;

module dehaze_recover_ch #(
  parameter int DW     = DEHAZE_DW,
  parameter int TW     = DEHAZE_TW,
  parameter int RF     = DEHAZE_RF,
  parameter int OFFSET = 0
) (
  input  logic             pixelclk,
  input  logic             reset_n,
  input  logic [DW-1:0]    i_pix,
  input  logic [DW-1:0]    i_atm,
  input  logic [TW+RF-1:0] i_recip,
  input  logic             i_de_s2,
  output logic [DW-1:0]    o_pix,
  output logic             o_clip
);
  localparam int PW = DW + TW + RF + 2;
  localparam int JW = PW + 2;
  localparam logic signed [PW-1:0] HALF = PW'(1 << (RF - 1));

  logic signed [DW:0]    diff_s1;
  logic [DW-1:0]         atm_s1;
  logic [DW-1:0]         atm_s2;
  logic signed [PW-1:0]  prod_s2;
  logic signed [PW-1:0]  diff_x;
  logic signed [PW-1:0]  recip_x;
  logic signed [PW-1:0]  q;
  logic signed [JW-1:0]  j;
  longint                j_cl;

  always_comb begin
    diff_x  = PW'(diff_s1);
    recip_x = PW'($signed({1'b0, i_recip}));
  end

  always_comb begin
    q      = (prod_s2 + HALF) >>> RF;
    j      = JW'(q) + JW'($signed({1'b0, atm_s2})) + JW'(OFFSET);
    j_cl   = clamp_fn(longint'(j), DW);
    o_clip = (j_cl != longint'(j));
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      diff_s1 <= '0;
      atm_s1  <= '0;
      atm_s2  <= '0;
      prod_s2 <= '0;
      o_pix   <= '0;
    end else begin
      diff_s1 <= $signed({1'b0, i_pix}) - $signed({1'b0, i_atm});
      atm_s1  <= i_atm;
      atm_s2  <= atm_s1;
      prod_s2 <= diff_x * recip_x;
      o_pix   <= i_de_s2 ? DW'(j_cl) : '0;
    end
  end
endmodule

// File: rtl/dehaze_recover.sv
// dehaze_recover: scene-radiance recovery J = A + (I-A)*(2^TW-1)/max(t,T_MIN) + OFFSET.
//   pixelclk, reset_n : clock, async active-low reset
//   bus (slave)       : i_data/i_t/i_atm/syncs in, o_data/syncs/o_clip_cnt out
// Three-stage pipeline; syncs are pure 3-cycle delays. A is latched on the
// i_vsync rising edge; the clip count is published on the o_vsync rising edge.
import dehaze_pkg::*;

module dehaze_recover #(
  parameter int DW     = DEHAZE_DW,
  parameter int CH     = 3,
  parameter int TW     = DEHAZE_TW,
  parameter int RF     = DEHAZE_RF,
  parameter int T_MIN  = 26,
  parameter int OFFSET = 0,
  parameter int CW     = 22
) (
  input logic             pixelclk,
  input logic             reset_n,
  dehaze_recover_if.slave bus
);
  localparam int RW = TW + RF;

  logic [CH*DW-1:0] atm_frame;
  logic             vsync_prev;
  logic [RW-1:0]    recip_rom [2**TW];
  logic [TW-1:0]    t_eff;
  logic [RW-1:0]    recip_s1;
  logic [2:0]       sync_s1;   // {hsync, vsync, de}
  logic [2:0]       sync_s2;
  logic [CH-1:0]    clip_ch;
  logic [CH*DW-1:0] data_s3;
  logic [CW-1:0]    clip_acc;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      atm_frame  <= '1;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= bus.i_vsync;
      if (bus.i_vsync && !vsync_prev) atm_frame <= bus.i_atm;
    end
  end

  // Constant-driven table; index 0 is unreachable because t_eff >= T_MIN >= 1.
  for (genvar g = 0; g < 2**TW; g++) begin : g_rom
    assign recip_rom[g] = (g == 0) ? '0 : RW'(recip_fn(g, TW, RF));
  end

  always_comb begin
    t_eff = (bus.i_t < TW'(T_MIN)) ? TW'(T_MIN) : bus.i_t;
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      recip_s1    <= '0;
      sync_s1     <= '0;
      sync_s2     <= '0;
      bus.o_hsync <= 1'b0;
      bus.o_vsync <= 1'b0;
      bus.o_de    <= 1'b0;
    end else begin
      recip_s1    <= recip_rom[t_eff];
      sync_s1     <= {bus.i_hsync, bus.i_vsync, bus.i_de};
      sync_s2     <= sync_s1;
      bus.o_hsync <= sync_s2[2];
      bus.o_vsync <= sync_s2[1];
      bus.o_de    <= sync_s2[0];
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    dehaze_recover_ch #(
      .DW     (DW),
      .TW     (TW),
      .RF     (RF),
      .OFFSET (OFFSET)
    ) u_ch (
      .pixelclk (pixelclk),
      .reset_n  (reset_n),
      .i_pix    (bus.i_data[(CH-1-c)*DW +: DW]),
      .i_atm    (atm_frame[(CH-1-c)*DW +: DW]),
      .i_recip  (recip_s1),
      .i_de_s2  (sync_s2[0]),
      .o_pix    (data_s3[(CH-1-c)*DW +: DW]),
      .o_clip   (clip_ch[c])
    );
  end

  assign bus.o_data = data_s3;

  // Publish/clear on the edge where o_vsync goes high; a clip in that cycle is dropped.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      clip_acc       <= '0;
      bus.o_clip_cnt <= '0;
    end else if (sync_s2[1] && !bus.o_vsync) begin
      bus.o_clip_cnt <= clip_acc;
      clip_acc       <= '0;
    end else if (sync_s2[0] && (|clip_ch) && (clip_acc != '1)) begin
      clip_acc <= clip_acc + 1'b1;
    end
  end
endmodule
